vending_machine_core: RTL and testbench

Parametrised, fully sequential vending-machine datapath and control core. It holds the credit register, a per-transaction inactivity timer and a three-state controller. It vends one item per cycle and returns change one coin per cycle using a greedy largest-coin-first policy. It sits between the coin/selection front end and the dispenser mechanics, and supersedes the fixed 3-coin/4-item combinational next-state logic with a self-contained block that supports arbitrary coin and item counts.

---
 rtl/vending_machine_core_pkg.sv | 6 +
 rtl/vending_machine_core_if.sv | 29 ++
 rtl/vending_machine_core_change_selector.sv | 25 ++
 rtl/vending_machine_core.sv | 134 +++++++++++++
 tb/tb_vending_machine_core.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vending_machine_core_pkg.sv
// vending_machine_core_pkg: shared state encoding and default coin/price tables
package vending_machine_core_pkg;
    typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_RETURN} state_e;
    localparam logic [47:0] DEF_COIN_VALUES = {16'd1000, 16'd500, 16'd100};
    localparam logic [63:0] DEF_ITEM_PRICES = {16'd2000, 16'd1000, 16'd500, 16'd400};
endpackage

// File: rtl/vending_machine_core_if.sv
// vending_machine_core_if: front-end coin/selection inputs and dispenser outputs of the core
interface vending_machine_core_if #(
    parameter int NUM_COINS  = 3,
    parameter int NUM_ITEMS  = 4,
    parameter int TOTAL_BITS = 16
);
    logic [NUM_COINS-1:0]            i_input_coin;
    logic [NUM_ITEMS-1:0]            i_select_item;
    logic                            i_trigger_return;
    logic [NUM_COINS*TOTAL_BITS-1:0] i_coin_value;
    logic [NUM_ITEMS*TOTAL_BITS-1:0] i_item_price;
    logic [NUM_ITEMS-1:0]            o_available_item;
    logic [NUM_ITEMS-1:0]            o_output_item;
    logic [NUM_COINS-1:0]            o_return_coin;
    logic                            o_coin_reject;
    logic                            o_residue;
    logic [TOTAL_BITS-1:0]           o_current_total;
    logic                            o_busy;
    modport master (
        output i_input_coin, i_select_item, i_trigger_return, i_coin_value, i_item_price,
        input  o_available_item, o_output_item, o_return_coin, o_coin_reject, o_residue,
               o_current_total, o_busy
    );
    modport slave (
        input  i_input_coin, i_select_item, i_trigger_return, i_coin_value, i_item_price,
        output o_available_item, o_output_item, o_return_coin, o_coin_reject, o_residue,
               o_current_total, o_busy
    );
endinterface

// File: rtl/vending_machine_core_change_selector.sv
// vending_machine_core_change_selector: greedy pick of the largest coin not exceeding the total
module vending_machine_core_change_selector #(
    parameter int NUM_COINS  = 3,
    parameter int TOTAL_BITS = 16
) (
    input  logic [TOTAL_BITS-1:0]           total_i,
    input  logic [NUM_COINS*TOTAL_BITS-1:0] coin_value_i,
    output logic [NUM_COINS-1:0]            coin_o,
    output logic [TOTAL_BITS-1:0]           value_o,
    output logic                            none_o
);
    always_comb begin
        coin_o  = '0;
        value_o = '0;
        none_o  = 1'b1;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (coin_value_i[k*TOTAL_BITS +: TOTAL_BITS] <= total_i) begin
                coin_o    = '0;
                coin_o[k] = 1'b1;
                value_o   = coin_value_i[k*TOTAL_BITS +: TOTAL_BITS];
                none_o    = 1'b0;
            end
        end
    end
endmodule

// File: rtl/vending_machine_core.sv
// vending_machine_core: credit register, inactivity timer and IDLE/CREDIT/RETURN controller
module vending_machine_core
    import vending_machine_core_pkg::*;
#(
    parameter int NUM_COINS   = 3,
    parameter int NUM_ITEMS   = 4,
    parameter int TOTAL_BITS  = 16,
    parameter int WAIT_CYCLES = 10
) (
    input logic                 clk,
    input logic                 reset,
    vending_machine_core_if.slave bus
);
    localparam int SW = TOTAL_BITS + $clog2(NUM_COINS + 1);
    localparam int TW = $clog2(WAIT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(WAIT_CYCLES);
    localparam logic [TOTAL_BITS-1:0] TOTAL_MAX = '1;

    state_e                state_q, state_d;
    logic [TOTAL_BITS-1:0] total_q, total_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [NUM_ITEMS-1:0]  item_q, item_d;
    logic [NUM_COINS-1:0]  ret_q, ret_d;
    logic                  reject_q, reject_d, residue_q, residue_d;
    logic [SW-1:0]         coin_sum, sum_total;
    logic                  coin_in, coin_ok;
    logic [NUM_ITEMS-1:0]  vend_oh, avail;
    logic [TOTAL_BITS-1:0] vend_price, pick_value;
    logic [NUM_COINS-1:0]  pick_coin;
    logic                  pick_none;

    vending_machine_core_change_selector #(.NUM_COINS(NUM_COINS), .TOTAL_BITS(TOTAL_BITS)) u_change (
        .total_i(total_q), .coin_value_i(bus.i_coin_value),
        .coin_o(pick_coin), .value_o(pick_value), .none_o(pick_none)
    );

    // Sum is kept wider than the credit so an overflowing insert is detectable
    always_comb begin
        coin_sum = '0;
        for (int k = 0; k < NUM_COINS; k++)
            coin_sum += bus.i_input_coin[k] ? SW'(bus.i_coin_value[k*TOTAL_BITS +: TOTAL_BITS]) : '0;
        sum_total = SW'(total_q) + coin_sum;
        coin_in   = |bus.i_input_coin;
        coin_ok   = coin_in && sum_total <= SW'(TOTAL_MAX);
    end

    // Descending scan so the lowest-index affordable selection wins
    always_comb begin
        vend_oh    = '0;
        vend_price = '0;
        avail      = '0;
        for (int k = NUM_ITEMS - 1; k >= 0; k--) begin
            avail[k] = state_q == S_CREDIT && bus.i_item_price[k*TOTAL_BITS +: TOTAL_BITS] <= total_q;
            if (bus.i_select_item[k] && bus.i_item_price[k*TOTAL_BITS +: TOTAL_BITS] <= total_q) begin
                vend_oh    = '0;
                vend_oh[k] = 1'b1;
                vend_price = bus.i_item_price[k*TOTAL_BITS +: TOTAL_BITS];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        total_d   = total_q;
        timer_d   = timer_q;
        item_d    = '0;
        ret_d     = '0;
        reject_d  = 1'b0;
        residue_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                reject_d = coin_in && !coin_ok;
                if (coin_ok) begin
                    state_d = S_CREDIT;
                    total_d = TOTAL_BITS'(sum_total);
                    timer_d = TIMER_LOAD;
                end
            end
            S_CREDIT: begin
                if (bus.i_trigger_return) begin
                    state_d  = S_RETURN;
                    reject_d = coin_in;
                end else begin
                    reject_d = coin_in && !coin_ok;
                    item_d   = vend_oh;
                    total_d  = TOTAL_BITS'((coin_ok ? sum_total : SW'(total_q)) - SW'(vend_price));
                    if (coin_ok || |vend_oh)
                        timer_d = TIMER_LOAD;
                    else if (timer_q == '0)
                        state_d = S_RETURN;
                    else
                        timer_d = timer_q - 1'b1;
                end
            end
            S_RETURN: begin
                reject_d  = coin_in;
                ret_d     = pick_coin;
                total_d   = pick_none ? '0 : total_q - pick_value;
                residue_d = pick_none && total_q != '0;
                if (pick_none || total_q == pick_value)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            total_q   <= '0;
            timer_q   <= '0;
            item_q    <= '0;
            ret_q     <= '0;
            reject_q  <= 1'b0;
            residue_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            total_q   <= total_d;
            timer_q   <= timer_d;
            item_q    <= item_d;
            ret_q     <= ret_d;
            reject_q  <= reject_d;
            residue_q <= residue_d;
        end
    end

    assign bus.o_available_item = avail;
    assign bus.o_output_item    = item_q;
    assign bus.o_return_coin    = ret_q;
    assign bus.o_coin_reject    = reject_q;
    assign bus.o_residue        = residue_q;
    assign bus.o_current_total  = total_q;
    assign bus.o_busy           = state_q == S_RETURN;
endmodule

// File: tb/tb_vending_machine_core.sv
// tb_vending_machine_core: scenario tasks against a queue of hand-derived per-cycle expectations
module tb_vending_machine_core;
    import vending_machine_core_pkg::*;

    typedef struct packed {
        logic [3:0]  avail;
        logic [3:0]  item;
        logic [2:0]  ret;
        logic        rej;
        logic        res;
        logic        busy;
        logic [15:0] total;
    } outs_t;

    typedef struct packed {
        logic [47:0] tbl;
        logic [2:0]  coin;
        logic [3:0]  sel;
        logic        trig;
    } stim_t;

    localparam outs_t Z = '0;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [47:0] cur_tbl = DEF_COIN_VALUES;
    stim_t stim_q[$];
    outs_t exp_q[$];
    int checks = 0;
    int fails = 0;

    vending_machine_core_if #(.NUM_COINS(3), .NUM_ITEMS(4), .TOTAL_BITS(16)) bus ();

    vending_machine_core #(.NUM_COINS(3), .NUM_ITEMS(4), .TOTAL_BITS(16), .WAIT_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic outs_t e(logic [3:0] avail, logic [3:0] item, logic [2:0] ret,
                                logic rej, logic res, logic busy, logic [15:0] total);
        return '{avail, item, ret, rej, res, busy, total};
    endfunction

    function automatic outs_t sample();
        return '{bus.o_available_item, bus.o_output_item, bus.o_return_coin, bus.o_coin_reject,
                 bus.o_residue, bus.o_busy, bus.o_current_total};
    endfunction

    task automatic pend(input logic [2:0] coin, input logic [3:0] sel, input logic trig, input outs_t x);
        stim_q.push_back('{cur_tbl, coin, sel, trig});
        exp_q.push_back(x);
    endtask

    task automatic drive(input stim_t x);
        bus.i_coin_value     = x.tbl;
        bus.i_input_coin     = x.coin;
        bus.i_select_item    = x.sel;
        bus.i_trigger_return = x.trig;
        @(posedge clk);
        #1;
        bus.i_input_coin     = '0;
        bus.i_select_item    = '0;
        bus.i_trigger_return = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        outs_t got;
        #1 reset = 1'b1;
        #1 got = sample();
        checks++;
        if (got !== Z) begin fails++; $display("FAIL reset_async got %p want %p", got, Z); end
        @(posedge clk);
        #1 reset = 1'b0;
        pend(3'b000, 4'b0000, 1'b0, Z);
        drive(stim_q.pop_front());
        got = sample();
        checks++;
        if (got !== exp_q[0]) begin fails++; $display("FAIL reset_idle got %p want %p", got, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_credit_vend();
        outs_t got, want;
        int k = 0;
        pend(3'b010, 4'b0000, 1'b0, e(4'b0011, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 16'd500));
        pend(3'b100, 4'b0000, 1'b0, e(4'b0111, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 16'd1500));
        pend(3'b000, 4'b0100, 1'b0, e(4'b0011, 4'b0100, 3'b000, 1'b0, 1'b0, 1'b0, 16'd500));
        pend(3'b000, 4'b0000, 1'b1, e(4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b1, 16'd500));
        pend(3'b000, 4'b0000, 1'b0, e(4'b0000, 4'b0000, 3'b010, 1'b0, 1'b0, 1'b0, 16'd0));
        pend(3'b000, 4'b0000, 1'b0, Z);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            got = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin fails++; $display("FAIL credit_vend step %0d got %p want %p", k, got, want); end
            k++;
        end
    endtask

    task automatic test_timeout();
        outs_t got, want;
        int k = 0;
        pend(3'b100, 4'b0000, 1'b0, e(4'b0111, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 16'd1000));
        for (int i = 0; i < 10; i++)
            pend(3'b000, 4'b0000, 1'b0, e(4'b0111, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 16'd1000));
        pend(3'b000, 4'b0000, 1'b0, e(4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b1, 16'd1000));
        pend(3'b000, 4'b0000, 1'b0, e(4'b0000, 4'b0000, 3'b100, 1'b0, 1'b0, 1'b0, 16'd0));
        pend(3'b000, 4'b0000, 1'b0, Z);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            got = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin fails++; $display("FAIL timeout step %0d got %p want %p", k, got, want); end
            k++;
        end
    endtask

    task automatic test_greedy_change();
        outs_t got, want;
        int k = 0;
        pend(3'b111, 4'b0000, 1'b0, e(4'b0111, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 16'd1600));
        pend(3'b000, 4'b0000, 1'b1, e(4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b1, 16'd1600));
        pend(3'b000, 4'b0001, 1'b1, e(4'b0000, 4'b0000, 3'b100, 1'b0, 1'b0, 1'b1, 16'd600));
        pend(3'b001, 4'b0000, 1'b0, e(4'b0000, 4'b0000, 3'b010, 1'b1, 1'b0, 1'b1, 16'd100));
        pend(3'b000, 4'b0000, 1'b0, e(4'b0000, 4'b0000, 3'b001, 1'b0, 1'b0, 1'b0, 16'd0));
        pend(3'b000, 4'b0000, 1'b0, Z);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            got = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin fails++; $display("FAIL greedy_change step %0d got %p want %p", k, got, want); end
            k++;
        end
    endtask

    task automatic test_select();
        outs_t got, want;
        int k = 0;
        pend(3'b010, 4'b0000, 1'b0, e(4'b0011, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 16'd500));
        pend(3'b000, 4'b0011, 1'b0, e(4'b0000, 4'b0001, 3'b000, 1'b0, 1'b0, 1'b0, 16'd100));
        pend(3'b100, 4'b0100, 1'b0, e(4'b0111, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 16'd1100));
        pend(3'b000, 4'b1000, 1'b0, e(4'b0111, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 16'd1100));
        pend(3'b001, 4'b0001, 1'b1, e(4'b0000, 4'b0000, 3'b000, 1'b1, 1'b0, 1'b1, 16'd1100));
        pend(3'b000, 4'b0000, 1'b0, e(4'b0000, 4'b0000, 3'b100, 1'b0, 1'b0, 1'b1, 16'd100));
        pend(3'b000, 4'b0000, 1'b0, e(4'b0000, 4'b0000, 3'b001, 1'b0, 1'b0, 1'b0, 16'd0));
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            got = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin fails++; $display("FAIL select step %0d got %p want %p", k, got, want); end
            k++;
        end
    endtask

    task automatic test_overflow();
        outs_t got, want;
        int k = 0;
        cur_tbl = {16'd32500, 16'd500, 16'd100};
        pend(3'b100, 4'b0000, 1'b0, e(4'b1111, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 16'd32500));
        pend(3'b100, 4'b0000, 1'b0, e(4'b1111, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 16'd65000));
        cur_tbl = DEF_COIN_VALUES;
        pend(3'b100, 4'b0000, 1'b0, e(4'b1111, 4'b0000, 3'b000, 1'b1, 1'b0, 1'b0, 16'd65000));
        pend(3'b010, 4'b0000, 1'b0, e(4'b1111, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 16'd65500));
        pend(3'b001, 4'b0001, 1'b0, e(4'b1111, 4'b0001, 3'b000, 1'b1, 1'b0, 1'b0, 16'd65100));
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            got = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin fails++; $display("FAIL overflow step %0d got %p want %p", k, got, want); end
            k++;
        end
        do_reset();
    endtask

    task automatic test_residue();
        outs_t got, want;
        int k = 0;
        pend(3'b001, 4'b0000, 1'b0, e(4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 16'd100));
        pend(3'b001, 4'b0000, 1'b0, e(4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 16'd200));
        cur_tbl = {16'd1000, 16'd500, 16'd300};
        pend(3'b000, 4'b0000, 1'b1, e(4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b1, 16'd200));
        pend(3'b000, 4'b0000, 1'b0, e(4'b0000, 4'b0000, 3'b000, 1'b0, 1'b1, 1'b0, 16'd0));
        pend(3'b000, 4'b0000, 1'b0, Z);
        cur_tbl = DEF_COIN_VALUES;
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            got = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin fails++; $display("FAIL residue step %0d got %p want %p", k, got, want); end
            k++;
        end
    endtask

    task automatic test_reset_mid_return();
        outs_t got, want;
        int k = 0;
        pend(3'b011, 4'b0000, 1'b0, e(4'b0011, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 16'd600));
        pend(3'b001, 4'b0000, 1'b0, e(4'b0011, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 16'd700));
        pend(3'b000, 4'b0000, 1'b1, e(4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b1, 16'd700));
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            got = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin fails++; $display("FAIL reset_mid_return step %0d got %p want %p", k, got, want); end
            k++;
        end
        #2 reset = 1'b1;
        #1 got = sample();
        checks++;
        if (got !== Z) begin fails++; $display("FAIL reset_mid_return async got %p want %p", got, Z); end
        @(posedge clk);
        #1 reset = 1'b0;
        pend(3'b000, 4'b0000, 1'b0, Z);
        drive(stim_q.pop_front());
        got = sample();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin fails++; $display("FAIL reset_mid_return after got %p want %p", got, want); end
    endtask

    initial begin
        bus.i_input_coin     = '0;
        bus.i_select_item    = '0;
        bus.i_trigger_return = 1'b0;
        bus.i_coin_value     = DEF_COIN_VALUES;
        bus.i_item_price     = DEF_ITEM_PRICES;
        test_reset();
        test_credit_vend();
        test_timeout();
        test_greedy_change();
        test_select();
        test_overflow();
        test_residue();
        test_reset_mid_return();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "watchdog");
    end
endmodule
